// File: rtl/dot_matrix_scan.sv
// Row-scanning driver for a 16x16 LED matrix: fetches each row's column word from the
// pattern ROMs, shows it with a blanking gap, and steps through patterns every few frames.
module dot_matrix_scan #(
   parameter int SCAN_DIV       = 3125,
   parameter int BLANK_CYC      = 16,
   parameter int FRAMES_PER_PAT = 250,
   parameter int NUM_PAT        = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] pat_col,
   output logic [3:0]  row_bin,
   output logic [3:0]  pat_sel,
   output logic [15:0] row,
   output logic [15:0] col,
   output logic        frame_tick
);

   localparam int SHOW_CYC = SCAN_DIV - 1 - BLANK_CYC;
   localparam int CNT_W    = $clog2(SCAN_DIV);
   localparam int FC_W     = $clog2(FRAMES_PER_PAT + 1);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAMES_PER_PAT - 1);
   localparam logic [3:0]       PAT_LAST   = 4'(NUM_PAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SHOW,
      BLANK
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [3:0]        row_bin_q, row_bin_d;
   logic [3:0]        pat_sel_q, pat_sel_d;
   logic [15:0]       row_q, row_d;
   logic [15:0]       col_q, col_d;
   logic              frame_tick_q, frame_tick_d;
   logic [15:0]       row_onehot;

   // One-hot row decode of the row currently presented to the ROMs.
   for (genvar gi = 0; gi < 16; gi++) begin : g_row_dec
      assign row_onehot[gi] = (row_bin_q == 4'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         frame_cnt_q  <= '0;
         row_bin_q    <= '0;
         pat_sel_q    <= '0;
         row_q        <= '0;
         col_q        <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         row_bin_q    <= row_bin_d;
         pat_sel_q    <= pat_sel_d;
         row_q        <= row_d;
         col_q        <= col_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_cnt_d  = frame_cnt_q;
      row_bin_d    = row_bin_q;
      pat_sel_d    = pat_sel_q;
      row_d        = row_q;
      col_d        = col_q;
      frame_tick_d = 1'b0;

      case (state_q)
         IDLE: begin
            row_d     = '0;
            col_d     = '0;
            row_bin_d = '0;
            cnt_d     = '0;
            if (en) begin
               state_d = FETCH;
            end
         end

         // row_bin has been stable for a full cycle here, so pat_col is settled.
         FETCH: begin
            col_d   = pat_col;
            row_d   = row_onehot;
            cnt_d   = '0;
            state_d = SHOW;
         end

         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               row_d   = '0;
               col_d   = '0;
               cnt_d   = '0;
               state_d = BLANK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BLANK: begin
            row_d = '0;
            col_d = '0;
            if (cnt_q == BLANK_LAST) begin
               cnt_d = '0;
               if (en) begin
                  row_bin_d = row_bin_q + 4'd1;
                  state_d   = FETCH;
                  // Pattern advances only at a frame boundary so no frame mixes patterns.
                  if (row_bin_q == 4'hF) begin
                     frame_tick_d = 1'b1;
                     if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        pat_sel_d   = (pat_sel_q == PAT_LAST) ? 4'd0 : pat_sel_q + 4'd1;
                     end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                     end
                  end
               end else begin
                  row_bin_d = '0;
                  state_d   = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign row_bin    = row_bin_q;
   assign pat_sel    = pat_sel_q;
   assign row        = row_q;
   assign col        = col_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Directed bench for dot_matrix_scan: a reset/first-slot vector table, then a cycle-exact
// slot model across frames, enable drop/resume and mid-scan reset.
module tb_dot_matrix_scan;

   localparam int SD   = 8;
   localparam int BL   = 2;
   localparam int FPP  = 2;
   localparam int NP   = 3;
   localparam int SHOW = SD - 1 - BL;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] pat_col;
   logic [3:0]  row_bin;
   logic [3:0]  pat_sel;
   logic [15:0] row;
   logic [15:0] col;
   logic        frame_tick;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Pattern ROM stand-in.
   assign pat_col = {pat_sel, 8'hA5, row_bin};

   dot_matrix_scan #(
      .SCAN_DIV      (SD),
      .BLANK_CYC     (BL),
      .FRAMES_PER_PAT(FPP),
      .NUM_PAT       (NP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .pat_col   (pat_col),
      .row_bin   (row_bin),
      .pat_sel   (pat_sel),
      .row       (row),
      .col       (col),
      .frame_tick(frame_tick)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] row;
      logic [15:0] col;
      logic [3:0]  row_bin;
      logic [3:0]  pat_sel;
      logic        tick;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] er, input logic [15:0] ec,
                        input logic [3:0] erb, input logic [3:0] eps, input logic et,
                        input bit verbose);
      vectors++;
      if (row !== er || col !== ec || row_bin !== erb || pat_sel !== eps || frame_tick !== et) begin
         miscompares++;
         $display("FAIL %s: got row=%h col=%h row_bin=%0d pat_sel=%0d tick=%b, want row=%h col=%h row_bin=%0d pat_sel=%0d tick=%b",
                  name, row, col, row_bin, pat_sel, frame_tick, er, ec, erb, eps, et);
      end else if (verbose) begin
         $display("ok   %s: row=%h col=%h row_bin=%0d pat_sel=%0d tick=%b",
                  name, row, col, row_bin, pat_sel, frame_tick);
      end
   endtask

   // k counts edges since the IDLE->FETCH edge; base is frames already completed.
   task automatic run_model(input int k_from, input int k_to, input int base, input string tag);
      for (int k = k_from; k <= k_to; k++) begin
         int          slot;
         int          phase;
         int          r;
         int          frames;
         logic [3:0]  p4;
         logic [3:0]  r4;
         logic [15:0] one;
         logic [15:0] er;
         logic [15:0] ec;
         logic        et;
         bit          lit;
         step();
         slot   = k / SD;
         phase  = k % SD;
         r      = slot % 16;
         frames = base + slot / 16;
         p4     = 4'((frames / FPP) % NP);
         r4     = 4'(r);
         one    = 16'h0001;
         lit    = (phase >= 1) && (phase <= SHOW);
         er     = lit ? (one << r) : 16'h0000;
         ec     = lit ? {p4, 8'hA5, r4} : 16'h0000;
         et     = (phase == 0) && (slot > 0) && (r == 0);
         check(tag, er, ec, r4, p4, et, et);
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;

      //            rst   en    row       col       rb    ps    tick
      vecs[0]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0}; // FETCH row 0
      vecs[4]  = '{1'b0, 1'b1, 16'h0001, 16'h0A50, 4'd0, 4'd0, 1'b0}; // SHOW x5
      vecs[5]  = '{1'b0, 1'b1, 16'h0001, 16'h0A50, 4'd0, 4'd0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 16'h0001, 16'h0A50, 4'd0, 4'd0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 16'h0001, 16'h0A50, 4'd0, 4'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 16'h0001, 16'h0A50, 4'd0, 4'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0}; // BLANK x2
      vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd1, 4'd0, 1'b0}; // FETCH row 1
      vecs[12] = '{1'b0, 1'b1, 16'h0002, 16'h0A51, 4'd1, 4'd0, 1'b0}; // SHOW row 1

      for (int i = 0; i < 13; i++) begin
         string nm;
         rst = vecs[i].rst;
         en  = vecs[i].en;
         step();
         nm = $sformatf("vec%0d", i);
         check(nm, vecs[i].row, vecs[i].col, vecs[i].row_bin, vecs[i].pat_sel, vecs[i].tick, 1'b1);
      end

      // Seven full frames covers pattern wrap 2->0, then stop mid-SHOW of row 7.
      run_model(10, 954, 0, "scan");

      en = 1'b0;
      run_model(955, 959, 0, "drain");
      step();
      check("idle_entry", 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b1);
      step();
      check("idle_hold", 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b1);

      // Resume: first tick lands 130 edges after IDLE entry; frame count carries over.
      en = 1'b1;
      run_model(0, 226, 7, "resume");

      // Mid-SHOW of row 12 with pat_sel=1.
      rst = 1'b1;
      step();
      check("rst_mid", 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b1);
      rst = 1'b0;
      run_model(0, 140, 0, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dot_matrix_scan.md
# dot_matrix_scan

Row-scanning driver for the 16×16 LED dot matrix. It reads the combinational pattern ROMs: it drives `row_bin` into the selected ROM and takes back that row's 16-bit `col` word. It then time-multiplexes the rows onto the matrix with a blanking gap between rows to prevent ghosting. It also sequences through the stored patterns, advancing to the next one after a fixed number of full frames.

## Interface
Parameters:
- `SCAN_DIV`, 3125: clock cycles per row slot. At 50 MHz this gives 16 kHz row rate and 1 kHz frame rate. Must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 16: cycles per row slot with all LEDs off. Must be ≥ 1.
- `FRAMES_PER_PAT`, 250: full frames shown per pattern. Must be ≥ 1.
- `NUM_PAT`, 10: number of pattern ROMs. `pat_sel` counts 0..`NUM_PAT`-1, with 1 ≤ `NUM_PAT` ≤ 16.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: scan enable.
- `pat_col`, in, 16: column word returned by the pattern ROM selected by `pat_sel` for the current `row_bin`. It is combinational and must settle in under one cycle.
- `row_bin`, out, 4: row index presented to the ROMs.
- `pat_sel`, out, 4: pattern ROM select.
- `row`, out, 16: one-hot row drive, active-high. Bit i lights row i.
- `col`, out, 16: column drive, active-high.
- `frame_tick`, out, 1: one-cycle pulse at each completed frame.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE. The row-slot counter and the frame counter also reset to 0.
- FSM states:
  - IDLE: `row`=0, `col`=0, `row_bin`=0. When `en`=1, go to FETCH.
  - FETCH (1 cycle): `row`=0 and `col`=0. `row_bin` holds the row for this slot. At the exit edge, `col` is loaded from `pat_col` and `row` is loaded with one-hot(`row_bin`). Go to SHOW.
  - SHOW (`SCAN_DIV`-1-`BLANK_CYC` cycles): `row` and `col` are held. At the exit edge both clear to 0. Go to BLANK.
  - BLANK (`BLANK_CYC` cycles): `row`=0, `col`=0. At the exit edge:
    - If `en`=1: `row_bin` increments with 15→0 wrap, and the FSM goes to FETCH.
    - If `en`=0: `row_bin` is forced to 0 and the FSM goes to IDLE. No `frame_tick` is generated, even if the row was 15.
- The row slot is always exactly `SCAN_DIV` cycles: FETCH + SHOW + BLANK.
- Deasserting `en` mid-slot does not abort the slot. The current SHOW/BLANK completes, and `en` is sampled only at BLANK exit.
- Frame end occurs at BLANK exit with `row_bin`=15 and `en`=1. On that edge:
  - `frame_tick` is set to 1, and clears on the next edge.
  - The frame counter increments. If it was `FRAMES_PER_PAT`-1, it returns to 0 and `pat_sel` increments, wrapping `NUM_PAT`-1→0.
- `pat_sel` changes only on a frame-end edge, so one frame never mixes two patterns.
- In IDLE, the frame counter and `pat_sel` are held. Resuming starts at row 0 of the same pattern, and that pattern's frame count continues.
- Invariant: `row` is never nonzero while `col` holds data for any row other than `row_bin`, and `row` is 0 for every FETCH and BLANK cycle.

## Timing
- Latency from `en` rising (sampled in IDLE) to the first lit row: 2 edges (IDLE→FETCH, FETCH→SHOW).
- `pat_col` is sampled exactly once per slot, at the FETCH exit edge, one full cycle after `row_bin` changes.
- Frame period is 16×`SCAN_DIV` cycles. `frame_tick` is spaced exactly that far apart while `en`=1.
- `rst` has priority over everything. When asserted in any state, the next edge clears all outputs and counters and returns the FSM to IDLE.

## Test plan
Bench parameters: `SCAN_DIV`=8, `BLANK_CYC`=2, `FRAMES_PER_PAT`=2, `NUM_PAT`=3. The model gives `pat_col` = {`pat_sel`, 8'hA5, `row_bin`}.
- Reset: hold `rst`=1 for 3 cycles with `en`=1 → `row`, `col`, `row_bin`, `pat_sel` and `frame_tick` are all 0, and they stay 0 for 1 cycle after release.
- First slot: `en`=1 after reset → 1 FETCH cycle with `row`=0. Then 5 cycles with `row`=16'h0001 and `col`=16'h0A50. Then 2 cycles with `row`=0 and `col`=0. Then `row_bin`=1, and row 1 shows `col`=16'h0A51.
- Frame/pattern sequencing: `en` held high → `frame_tick` pulses every 128 cycles for exactly 1 cycle. `pat_sel` goes 0→1 at the 2nd tick, 1→2 at the 4th, and 2→0 at the 6th.
- Enable drop: `en`=0 mid-SHOW of row 7 → row 7 finishes its SHOW and BLANK, then IDLE with `row_bin`=0 and no `frame_tick`. On re-enable, the scan restarts at row 0 with the same `pat_sel`, and the next `frame_tick` arrives 130 cycles later.
- Reset mid-operation: `rst` pulsed during SHOW of row 12 with `pat_sel`=1 → on the next edge all outputs are 0 and the FSM is in IDLE. After release, the scan restarts with `pat_sel`=0.
- Ghost check: across 3 full frames, for every cycle with `row`≠0, `row` equals one-hot(`row_bin`) and `col` equals the model value for that row.
